hazard_stall_unit: RTL and testbench

- ID-stage hazard detection unit for the 5-stage MIPS pipeline.
- Covers the hazards the EX-stage ALU forwarding unit cannot resolve: load-use, and branches compared in ID that depend on in-flight results.
- When a hazard is found it freezes PC and IF/ID, injects bubbles into ID/EX, and flushes IF/ID on a taken branch.
- Stall length is registered at detection and counted down by an FSM. It does not depend on re-evaluating ID/EX, which holds a bubble after the first stall cycle.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/hazard_stall_unit_if.sv | 45 ++++
 rtl/hazard_stall_unit_sat_counter.sv | 32 +++
 rtl/hazard_stall_unit.sv | 117 +++++++++++
 tb/tb_hazard_stall_unit.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Brief    : Shared encodings and constants for the ID-stage hazard stall unit.
// Revision : 1.0
// ============================================================================
package pipe_pkg;

  localparam logic [0:0] ST_RUN         = 1'b0;
  localparam logic [0:0] ST_STALL       = 1'b1;

  localparam logic [4:0] REG_ZERO       = 5'd0;

  localparam logic [1:0] STALL_NONE     = 2'd0;
  localparam logic [1:0] STALL_LOAD_USE = 2'd1;
  localparam logic [1:0] STALL_BR_LOAD  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/hazard_stall_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_unit_if
// Brief    : Pipeline-register view and control outputs of the hazard unit.
// Revision : 1.0
// ============================================================================
interface hazard_stall_unit_if #(parameter int CNT_W = 16);

  logic [4:0]       IFID_RegisterRs;
  logic [4:0]       IFID_RegisterRt;
  logic             IFID_UsesRt;
  logic             IFID_MemWrite;
  logic             IFID_Branch;
  logic             IDEX_MemRead;
  logic             IDEX_RegWrite;
  logic [4:0]       IDEX_RegisterRd;
  logic             EXMEM_MemRead;
  logic [4:0]       EXMEM_RegisterRd;
  logic             branch_taken;
  logic             PCWrite;
  logic             IFIDWrite;
  logic             IDEX_Bubble;
  logic             IFID_Flush;
  logic             stalled;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] stall_events;

  modport master (
    output IFID_RegisterRs, IFID_RegisterRt, IFID_UsesRt, IFID_MemWrite,
           IFID_Branch, IDEX_MemRead, IDEX_RegWrite, IDEX_RegisterRd,
           EXMEM_MemRead, EXMEM_RegisterRd, branch_taken,
    input  PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush, stalled,
           stall_cycles, stall_events
  );

  modport slave (
    input  IFID_RegisterRs, IFID_RegisterRt, IFID_UsesRt, IFID_MemWrite,
           IFID_Branch, IDEX_MemRead, IDEX_RegWrite, IDEX_RegisterRd,
           EXMEM_MemRead, EXMEM_RegisterRd, branch_taken,
    output PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush, stalled,
           stall_cycles, stall_events
  );

endinterface
`default_nettype wire

// File: rtl/hazard_stall_unit_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Up-counter that sticks at all-ones instead of wrapping.
// Revision : 1.0
// ============================================================================
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_unit
// Brief    : ID-stage load-use / branch-dependence stall and flush control.
// Revision : 1.0
// ============================================================================
module hazard_stall_unit
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  hazard_stall_unit_if.slave bus
);

  logic [0:0] r_state;
  logic [0:0] w_stateNext;
  logic [1:0] r_remaining;
  logic [1:0] w_remainingNext;
  logic       w_mExRs;
  logic       w_mExRt;
  logic       w_mMemRs;
  logic       w_mMemRt;
  logic [1:0] w_need;
  logic       w_detect;
  logic       w_frozen;

  assign w_mExRs  = bus.IDEX_RegWrite && (bus.IDEX_RegisterRd != REG_ZERO) &&
                    (bus.IDEX_RegisterRd == bus.IFID_RegisterRs);
  assign w_mExRt  = bus.IDEX_RegWrite && bus.IFID_UsesRt && (bus.IDEX_RegisterRd != REG_ZERO) &&
                    (bus.IDEX_RegisterRd == bus.IFID_RegisterRt);
  assign w_mMemRs = bus.EXMEM_MemRead && (bus.EXMEM_RegisterRd != REG_ZERO) &&
                    (bus.EXMEM_RegisterRd == bus.IFID_RegisterRs);
  assign w_mMemRt = bus.EXMEM_MemRead && bus.IFID_UsesRt && (bus.EXMEM_RegisterRd != REG_ZERO) &&
                    (bus.EXMEM_RegisterRd == bus.IFID_RegisterRt);

  // Stall length is only meaningful in RUN; a lw->sw store-data dependence is forwarded mem-to-mem.
  always_comb begin
    w_need = STALL_NONE;
    if (r_state == ST_RUN) begin
      if (bus.IFID_Branch) begin
        if (bus.IDEX_MemRead && (w_mExRs || w_mExRt)) begin
          w_need = STALL_BR_LOAD;
        end else if ((!bus.IDEX_MemRead && (w_mExRs || w_mExRt)) || w_mMemRs || w_mMemRt) begin
          w_need = STALL_LOAD_USE;
        end
      end else if (bus.IDEX_MemRead && (w_mExRs || (w_mExRt && !bus.IFID_MemWrite))) begin
        w_need = STALL_LOAD_USE;
      end
    end
  end

  assign w_detect = (w_need != STALL_NONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_RUN;
      r_remaining <= 2'd0;
    end else begin
      r_state     <= w_stateNext;
      r_remaining <= w_remainingNext;
    end
  end

  always_comb begin
    w_stateNext     = r_state;
    w_remainingNext = r_remaining;
    case (r_state)
      ST_RUN: begin
        if (w_detect) begin
          w_remainingNext = w_need - 2'd1;
          w_stateNext     = ((w_need - 2'd1) != 2'd0) ? ST_STALL : ST_RUN;
        end
      end
      ST_STALL: begin
        w_remainingNext = r_remaining - 2'd1;
        if ((r_remaining - 2'd1) == 2'd0) begin
          w_stateNext = ST_RUN;
        end
      end
      default: begin
        w_stateNext     = ST_RUN;
        w_remainingNext = 2'd0;
      end
    endcase
  end

  // Gated by reset_n so garbage inputs during reset cannot freeze the pipe.
  always_comb begin
    w_frozen        = reset_n && ((r_state == ST_STALL) || w_detect);
    bus.PCWrite     = !w_frozen;
    bus.IFIDWrite   = !w_frozen;
    bus.IDEX_Bubble = w_frozen;
    bus.stalled     = w_frozen;
    bus.IFID_Flush  = reset_n && (r_state == ST_RUN) && !w_detect &&
                      bus.IFID_Branch && bus.branch_taken;
  end

  sat_counter #(.W(CNT_W)) u_cycleCnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (w_frozen),
    .clear   (1'b0),
    .count   (bus.stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_eventCnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (reset_n && w_detect),
    .clear   (1'b0),
    .count   (bus.stall_events)
  );

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_stall_unit
// Brief    : Directed bench with a behavioural stall model for hazard_stall_unit.
// Revision : 1.0
// ============================================================================
module tb_hazard_stall_unit;

  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  // Model state: frozen cycles still owed after the current one, and counters.
  int   mLeft = 0;
  int   mCyc = 0;
  int   mEv = 0;

  always #5 clk = ~clk;

  hazard_stall_unit_if #(.CNT_W(CNT_W)) bus ();

  hazard_stall_unit #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Stall length from the hazard rules, phrased as register dependences.
  function automatic int needN();
    bit exRs, exRt, memRs, memRt, exDep, memDep;
    exRs  = bus.IDEX_RegWrite && bus.IDEX_RegisterRd != 0 && bus.IDEX_RegisterRd == bus.IFID_RegisterRs;
    exRt  = bus.IDEX_RegWrite && bus.IFID_UsesRt && bus.IDEX_RegisterRd != 0 &&
            bus.IDEX_RegisterRd == bus.IFID_RegisterRt;
    memRs = bus.EXMEM_MemRead && bus.EXMEM_RegisterRd != 0 && bus.EXMEM_RegisterRd == bus.IFID_RegisterRs;
    memRt = bus.EXMEM_MemRead && bus.IFID_UsesRt && bus.EXMEM_RegisterRd != 0 &&
            bus.EXMEM_RegisterRd == bus.IFID_RegisterRt;
    exDep  = exRs || exRt;
    memDep = memRs || memRt;
    if (bus.IFID_Branch) begin
      if (exDep && bus.IDEX_MemRead) return 2;
      if (exDep || memDep) return 1;
      return 0;
    end
    if (bus.IDEX_MemRead && exRs) return 1;
    if (bus.IDEX_MemRead && exRt && !bus.IFID_MemWrite) return 1;
    return 0;
  endfunction

  always @(negedge reset_n) begin
    mLeft = 0;
    mCyc  = 0;
    mEv   = 0;
  end

  always @(negedge clk) begin
    int  n;
    bit  frz, flush;
    if (!reset_n) begin
      mLeft = 0; mCyc = 0; mEv = 0;
      frz = 1'b0; flush = 1'b0; n = 0;
    end else if (mLeft > 0) begin
      n = 0; frz = 1'b1; flush = 1'b0;
    end else begin
      n = needN();
      frz = (n > 0);
      flush = (n == 0) && bus.IFID_Branch && bus.branch_taken;
    end
    chk("PCWrite",      int'(bus.PCWrite),     int'(!frz));
    chk("IFIDWrite",    int'(bus.IFIDWrite),   int'(!frz));
    chk("IDEX_Bubble",  int'(bus.IDEX_Bubble), int'(frz));
    chk("stalled",      int'(bus.stalled),     int'(frz));
    chk("IFID_Flush",   int'(bus.IFID_Flush),  int'(flush));
    chk("stall_cycles", int'(bus.stall_cycles), mCyc);
    chk("stall_events", int'(bus.stall_events), mEv);
    if (reset_n) begin
      if (frz) mCyc = (mCyc < SAT) ? mCyc + 1 : SAT;
      if (mLeft > 0) mLeft = mLeft - 1;
      else if (n > 0) begin
        mLeft = n - 1;
        mEv = (mEv < SAT) ? mEv + 1 : SAT;
      end
    end
  end

  task automatic clearIn();
    bus.IFID_RegisterRs = 5'd0; bus.IFID_RegisterRt = 5'd0;
    bus.IFID_UsesRt = 1'b0; bus.IFID_MemWrite = 1'b0; bus.IFID_Branch = 1'b0;
    bus.IDEX_MemRead = 1'b0; bus.IDEX_RegWrite = 1'b0; bus.IDEX_RegisterRd = 5'd0;
    bus.EXMEM_MemRead = 1'b0; bus.EXMEM_RegisterRd = 5'd0; bus.branch_taken = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic lwInEx(input logic [4:0] rd);
    bus.IDEX_MemRead = 1'b1; bus.IDEX_RegWrite = 1'b1; bus.IDEX_RegisterRd = rd;
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    clearIn();
    bus.IFID_RegisterRs = 5'd9; bus.IDEX_MemRead = 1'b1; bus.IDEX_RegWrite = 1'b1;
    bus.IDEX_RegisterRd = 5'd9;
    #2;
    chk("rst_PCWrite", int'(bus.PCWrite), 1);
    chk("rst_Bubble",  int'(bus.IDEX_Bubble), 0);
    chk("rst_cycles",  int'(bus.stall_cycles), 0);
    step(); step();
    clearIn();
    reset_n = 1'b1;
    step();

    // load-use: lw $5 ; add uses $5
    lwInEx(5'd5); bus.IFID_RegisterRs = 5'd5; bus.IFID_RegisterRt = 5'd6; bus.IFID_UsesRt = 1'b1;
    settle();
    chk("lu_PCWrite", int'(bus.PCWrite), 0);
    chk("lu_Bubble",  int'(bus.IDEX_Bubble), 1);
    step();
    bus.IDEX_MemRead = 1'b0; bus.IDEX_RegWrite = 1'b0; bus.IDEX_RegisterRd = 5'd0;
    settle();
    chk("lu_rel_PCWrite", int'(bus.PCWrite), 1);
    chk("lu_cycles", int'(bus.stall_cycles), 1);
    chk("lu_events", int'(bus.stall_events), 1);
    step();

    // lw -> sw store-data only: exempt; base register dependence stalls
    clearIn();
    lwInEx(5'd5); bus.IFID_RegisterRs = 5'd2; bus.IFID_RegisterRt = 5'd5;
    bus.IFID_UsesRt = 1'b1; bus.IFID_MemWrite = 1'b1;
    settle();
    chk("sw_data_PCWrite", int'(bus.PCWrite), 1);
    step();
    bus.IFID_RegisterRs = 5'd5;
    settle();
    chk("sw_base_PCWrite", int'(bus.PCWrite), 0);
    step();
    clearIn();
    doReset();

    // lw $7 ; beq $7 -> two cycles held by the registered length
    lwInEx(5'd7); bus.IFID_Branch = 1'b1; bus.IFID_RegisterRs = 5'd7;
    settle();
    chk("brld_c1_PCWrite", int'(bus.PCWrite), 0);
    step();
    bus.IDEX_MemRead = 1'b0; bus.IDEX_RegWrite = 1'b0; bus.IDEX_RegisterRd = 5'd0;
    settle();
    chk("brld_c2_PCWrite", int'(bus.PCWrite), 0);
    chk("brld_c2_stalled", int'(bus.stalled), 1);
    step();
    settle();
    chk("brld_rel_PCWrite", int'(bus.PCWrite), 1);
    chk("brld_cycles", int'(bus.stall_cycles), 2);
    chk("brld_events", int'(bus.stall_events), 1);
    step();

    // add $3 ; bne rt=$3 taken -> one stall, flush only on release
    clearIn();
    bus.IDEX_RegWrite = 1'b1; bus.IDEX_RegisterRd = 5'd3;
    bus.IFID_Branch = 1'b1; bus.IFID_RegisterRs = 5'd4; bus.IFID_RegisterRt = 5'd3;
    bus.IFID_UsesRt = 1'b1; bus.branch_taken = 1'b1;
    settle();
    chk("br_stall_PCWrite", int'(bus.PCWrite), 0);
    chk("br_stall_Flush",   int'(bus.IFID_Flush), 0);
    step();
    bus.IDEX_RegWrite = 1'b0; bus.IDEX_RegisterRd = 5'd0;
    settle();
    chk("br_rel_Flush",   int'(bus.IFID_Flush), 1);
    chk("br_rel_PCWrite", int'(bus.PCWrite), 1);
    step();
    clearIn();
    settle();
    chk("br_after_Flush", int'(bus.IFID_Flush), 0);

    // $0 never stalls
    lwInEx(5'd0); bus.IFID_RegisterRs = 5'd0;
    settle();
    chk("r0_PCWrite", int'(bus.PCWrite), 1);
    step();

    // async reset in the second cycle of a two-cycle stall
    clearIn();
    lwInEx(5'd7); bus.IFID_Branch = 1'b1; bus.IFID_RegisterRs = 5'd7;
    step();
    settle();
    chk("mid_c2_PCWrite", int'(bus.PCWrite), 0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_PCWrite", int'(bus.PCWrite), 1);
    chk("mid_rst_Bubble",  int'(bus.IDEX_Bubble), 0);
    chk("mid_rst_cycles",  int'(bus.stall_cycles), 0);
    chk("mid_rst_events",  int'(bus.stall_events), 0);
    step();
    clearIn();
    reset_n = 1'b1;
    step();

    // saturation: 2^CNT_W+3 back-to-back load-use stalls
    lwInEx(5'd8); bus.IFID_RegisterRs = 5'd8;
    for (int i = 0; i < (1 << CNT_W) + 3; i++) step();
    clearIn();
    settle();
    chk("sat_cycles", int'(bus.stall_cycles), SAT);
    chk("sat_events", int'(bus.stall_events), SAT);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
